// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit positions and the transmit FSM state encoding.
package mmio_uart_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_1000;

    // Word offsets within the 16-byte window, taken from dram_addr[3:2].
    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_DIV    = 2'd2;

    // STATUS register bit positions.
    localparam int STAT_BUSY     = 0;
    localparam int STAT_FULL     = 1;
    localparam int STAT_EMPTY    = 2;
    localparam int STAT_OVERFLOW = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO holding bytes waiting for transmission. A push into
// a full FIFO is accepted when a pop happens on the same edge.
module uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage write; pointers alone define which entries are valid.
    // NOTE: the data array has no reset -- flushing the pointers is enough and keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap at the power-of-2 depth.
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores fill a byte FIFO, a
// baud-rate FSM serialises bytes onto tx; STATUS and DIV are readable.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0]      BASE_ADDR  = DEFAULT_BASE_ADDR,
    parameter int               DIV_W      = 16,
    parameter logic [DIV_W-1:0] DIV_RESET  = DIV_W'(16),
    parameter int               FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dram_read,
    input  logic        dram_write,
    input  logic [31:0] dram_addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        tx,
    output logic        irq_empty
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic             sel, wr_sel, push_req;
    logic [1:0]       off;
    logic             fifo_pop, fifo_full, fifo_empty;
    logic [7:0]       fifo_dout;
    logic [CW-1:0]    fifo_count;

    tx_state_e        state_q, state_d;
    logic [DIV_W-1:0] baud_q, baud_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] eff_div_m1;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             ovf_q, ovf_d;
    logic             busy, bit_end;

    assign sel        = (dram_addr[31:4] == BASE_ADDR[31:4]);
    assign off        = dram_addr[3:2];
    assign wr_sel     = dram_write && sel;
    assign push_req   = wr_sel && (off == OFF_TXDATA);
    assign busy       = (state_q != ST_IDLE);
    assign bit_end    = (baud_q == '0);
    assign eff_div_m1 = (div_q == '0) ? '0 : div_q - DIV_W'(1);
    assign tx         = tx_q;
    assign irq_empty  = fifo_empty && !busy;

    // Byte-lane and count bits that the register map does not consume.
    logic unused_bits;
    assign unused_bits = ^{dram_addr[1:0], write_data, fifo_count};

    uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (fifo_pop),
        .din   (write_data[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Register writes: DIV load, overflow set on a dropped push, write-1-to-clear.
    always_comb begin
        div_d = div_q;
        ovf_d = ovf_q;
        if (wr_sel && (off == OFF_DIV)) begin
            div_d = write_data[DIV_W-1:0];
        end
        if (push_req && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end else if (wr_sel && (off == OFF_STATUS) && write_data[STAT_OVERFLOW]) begin
            ovf_d = 1'b0;
        end
    end

    // Transmit FSM next state; STOP chains straight into START when a byte waits.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    baud_d   = eff_div_m1;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                    baud_d    = eff_div_m1;
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    baud_d  = eff_div_m1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        baud_d   = eff_div_m1;
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Serial line value for the coming cycle, registered so tx never glitches.
    always_comb begin
        unique case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // State registers; reset abandons any frame in flight and returns tx high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            div_q     <= DIV_RESET;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            div_q     <= div_d;
            ovf_q     <= ovf_d;
        end
    end

    // Zero-latency load data; unselected or no-read cycles return zero.
    always_comb begin
        read_data = 32'h0;
        if (dram_read && sel) begin
            unique case (off)
                OFF_STATUS: read_data = {28'b0, ovf_q, fifo_empty, fifo_full, busy};
                OFF_DIV:    read_data = 32'(div_q);
                default:    read_data = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: directed scenarios plus randomized
// frame trials checked against a frame-timing model of the serial line.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam logic [31:0] A_TX   = BASE + 32'h0;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_DIV  = BASE + 32'h8;
    localparam logic [31:0] A_RSV  = BASE + 32'hC;

    typedef logic [7:0] bq_t [$];
    typedef int         iq_t [$];

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dram_read = 1'b0;
    logic        dram_write = 1'b0;
    logic [31:0] dram_addr = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic [31:0] read_data;
    logic        tx;
    logic        irq_empty;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic tx_log [0:32767];

    // Frame model: each frame has a start cycle, a byte, and per-bit lengths
    // (bits below fr_sw use fr_d0 cycles, the rest fr_d1).
    int         fr_start [8];
    logic [7:0] fr_byte  [8];
    int         fr_d0    [8];
    int         fr_d1    [8];
    int         fr_sw    [8];
    int         nfr;
    int         model_begin, model_end;

    mmio_uart_tx dut (
        .clk        (clk),
        .reset      (reset),
        .dram_read  (dram_read),
        .dram_write (dram_write),
        .dram_addr  (dram_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .tx         (tx),
        .irq_empty  (irq_empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) tx_log[cyc % 32768] = tx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int bit_len(int k, int b);
        return (b < fr_sw[k]) ? fr_d0[k] : fr_d1[k];
    endfunction

    function automatic int frame_len(int k);
        int s = 0;
        for (int b = 0; b < 10; b++) s += bit_len(k, b);
        return s;
    endfunction

    // Expected line level sampled in the cycle after rising edge number c.
    function automatic logic exp_tx(int c);
        for (int k = 0; k < nfr; k++) begin
            int o = c - fr_start[k];
            if (o >= 0 && o < frame_len(k)) begin
                for (int b = 0; b < 10; b++) begin
                    if (o < bit_len(k, b)) begin
                        if (b == 0) return 1'b0;
                        if (b == 9) return 1'b1;
                        return fr_byte[k][b-1];
                    end
                    o -= bit_len(k, b);
                end
            end
        end
        return 1'b1;
    endfunction

    task automatic bus_idle();
        @(negedge clk);
        dram_write = 1'b0;
        dram_read  = 1'b0;
    endtask

    task automatic drive_write(input logic [31:0] a, input logic [31:0] d, output int e);
        @(negedge clk);
        dram_read  = 1'b0;
        dram_write = 1'b1;
        dram_addr  = a;
        write_data = d;
        e = cyc + 1;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        dram_write = 1'b0;
        dram_read  = 1'b1;
        dram_addr  = a;
        #1 d = read_data;
        #1 dram_read = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (irq_empty !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'b0, irq_empty}, 32'h1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // Program DIV, push bytes with the given idle gaps, and build the model.
    task automatic push_frames(input int div, input bq_t bytes, input iq_t gaps);
        int e, st, pe;
        int eff = (div == 0) ? 1 : div;
        drive_write(A_DIV, 32'(div), e);
        nfr = 0;
        pe  = -1000000;
        foreach (bytes[i]) begin
            repeat (gaps[i]) bus_idle();
            drive_write(A_TX, {24'h0, bytes[i]}, e);
            if (i == 0) model_begin = e;
            st = (e + 1 > pe) ? e + 1 : pe;
            fr_start[nfr] = st;
            fr_byte[nfr]  = bytes[i];
            fr_d0[nfr]    = eff;
            fr_d1[nfr]    = eff;
            fr_sw[nfr]    = 10;
            pe = st + frame_len(nfr);
            nfr++;
        end
        bus_idle();
        model_end = pe;
    endtask

    task automatic finish_frames(input string tag);
        int errs = 0;
        wait_cyc(model_end + 5);
        for (int c = model_begin; c <= model_end + 4; c++) begin
            if (tx_log[c % 32768] !== exp_tx(c)) errs++;
        end
        check(tag, 32'(errs), 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        int e, s, z;
        bq_t bq;
        iq_t gq;

        // Reset and idle register state.
        do_reset();
        #1;
        check("rst_tx", {31'b0, tx}, 32'h1);
        check("rst_irq", {31'b0, irq_empty}, 32'h1);
        check("no_read_zero", read_data, 32'h0);
        bus_read(A_STAT, rd); check("rst_status", rd, 32'h4);
        bus_read(A_DIV, rd);  check("rst_div", rd, 32'd16);
        bus_read(A_TX, rd);   check("txdata_reads_0", rd, 32'h0);
        bus_read(A_RSV, rd);  check("reserved_reads_0", rd, 32'h0);
        bus_read(32'h0000_2004, rd); check("unselected_reads_0", rd, 32'h0);

        // Single frame, DIV=4.
        bq = {8'hA5}; gq = {0};
        push_frames(4, bq, gq);
        finish_frames("frame_a5_div4");
        check("a5_frame_len", 32'(model_end - fr_start[0]), 32'd40);
        bus_read(A_STAT, rd); check("a5_status_after", rd, 32'h4);
        check("a5_irq_after", {31'b0, irq_empty}, 32'h1);

        // Back-to-back frames, DIV=2.
        bq = {8'h01, 8'h02, 8'h03}; gq = {0, 0, 0};
        push_frames(2, bq, gq);
        wait_cyc(fr_start[2] + 1);
        bus_read(A_STAT, rd); check("b2b_empty_busy", rd, 32'h5);
        finish_frames("frames_b2b_div2");

        // DIV=0 gives one-cycle bits.
        bq = {8'h3C}; gq = {0};
        push_frames(0, bq, gq);
        finish_frames("frame_div0");
        bus_read(A_DIV, rd); check("div0_readback", rd, 32'h0);

        // DIV change mid data bit: current bit keeps old length.
        wait_idle("idle_before_divchg", 1000);
        bq = {8'h0F}; gq = {0};
        push_frames(4, bq, gq);
        s = fr_start[0];
        wait_cyc(s + 3);
        drive_write(A_DIV, 32'd8, e);
        bus_idle();
        fr_d1[0] = 8;
        fr_sw[0] = 2;
        model_end = s + frame_len(0);
        check("divchg_mid_bit0", {31'b0, (e > s + 4 && e < s + 8)}, 32'h1);
        finish_frames("frame_div_change");
        bus_read(A_DIV, rd); check("divchg_readback", rd, 32'd8);

        // Randomized trials (at most 5 bytes so the FIFO never overflows).
        for (int t = 0; t < 6; t++) begin
            int n = $urandom_range(1, 5);
            int d = $urandom_range(0, 5);
            wait_idle($sformatf("idle_before_rand%0d", t), 2000);
            bq.delete(); gq.delete();
            for (int i = 0; i < n; i++) begin
                bq.push_back(8'($urandom));
                gq.push_back($urandom_range(0, 3) * (($urandom_range(0, 2) == 0) ? 8 : 1));
            end
            push_frames(d, bq, gq);
            finish_frames($sformatf("rand%0d_div%0d_n%0d", t, d, n));
        end

        // Overflow: sixth byte dropped, then write-1-to-clear.
        wait_idle("idle_before_ovf", 2000);
        drive_write(A_DIV, 32'd100, e);
        for (int i = 0; i < 6; i++) drive_write(A_TX, 32'(8'h10 + i), e);
        bus_read(A_STAT, rd); check("ovf_status", rd, 32'hB);
        drive_write(A_STAT, 32'h8, e);
        bus_read(A_STAT, rd); check("ovf_cleared", rd, 32'h3);
        do_reset();
        #1 check("ovf_reset_irq", {31'b0, irq_empty}, 32'h1);

        // Reset during DATA bit 3 with two bytes still queued.
        bq = {8'hF7, 8'h55, 8'hAA}; gq = {0, 0, 0};
        push_frames(4, bq, gq);
        s = fr_start[0];
        wait_cyc(s + 17);
        check("pre_reset_bit3", {31'b0, tx}, 32'h0);
        #2 reset = 1'b1;
        #1;
        check("async_reset_tx", {31'b0, tx}, 32'h1);
        check("async_reset_irq", {31'b0, irq_empty}, 32'h1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus_read(A_STAT, rd); check("post_reset_status", rd, 32'h4);
        bus_read(A_DIV, rd);  check("post_reset_div", rd, 32'd16);
        z = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) z++;
        end
        check("no_frames_after_reset", 32'(z), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the CPU data-memory bus, in parallel with dram.
- Board-level address decode steers a 16-byte window at BASE_ADDR to this block.
- CPU stores push bytes into a small FIFO; a baud-rate FSM serialises them onto tx (8N1).
- Status and divisor registers are readable, so firmware can poll instead of stall. The bus never waits.

Parameters:
- BASE_ADDR, 32'h0000_1000, base of the register window; low 4 bits must be zero.
- DIV_RESET, 16, divisor value after reset, in clk cycles per bit.
- DIV_W, 16, divisor register width.
- FIFO_DEPTH, 4, TX FIFO entries; must be a power of 2, at least 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- dram_read  in  1  CPU load strobe.
- dram_write  in  1  CPU store strobe.
- dram_addr  in  32  byte address.
- write_data  in  32  store data.
- read_data  out  32  load data; combinational.
- tx  out  1  serial output; idle high.
- irq_empty  out  1  high when FIFO is empty and FSM is IDLE.

Behaviour:
- Select: sel = (dram_addr[31:4] == BASE_ADDR[31:4]). Offset = dram_addr[3:2]. dram_addr[1:0] are ignored.
- Registers:
  - 0x0 TXDATA: write pushes write_data[7:0]; reads return 0.
  - 0x4 STATUS: read {28'b0, overflow, empty, full, busy}; writing 1 to bit3 clears overflow.
  - 0x8 DIV: R/W, DIV_W bits, zero-extended on read.
  - 0xC: reserved; reads 0, writes ignored.
- read_data equals the selected register when dram_read && sel, else 32'h0. No latency.
- Writes take effect at the clk edge on which dram_write && sel.
- Push to a full FIFO:
  - Byte is dropped and overflow is set.
  - Exception: if a pop occurs on the same edge, the push is accepted and count is unchanged.
- dram_read and dram_write asserted together: the read is combinational and the write commits at the edge; both are honoured.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO not empty (registered count), pop into shift register, load baud counter, go to START. tx falls on the edge after the push edge, so first-bit latency is 1 cycle after push.
  - START: tx=0 for div cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for div cycles; shift right, increment index. After index 7 completes, go to STOP.
  - STOP: tx=1 for div cycles, then return to IDLE.
  - IDLE re-checks the FIFO in the same cycle it is entered, so back-to-back frames have no extra idle bit.
- Baud counter:
  - Loads eff_div-1 at each bit start and counts down; the bit ends when it reaches 0.
  - eff_div = (DIV==0) ? 1 : DIV.
  - A DIV write mid-frame takes effect at the next bit boundary; the current bit is not truncated.
- Frame length is exactly 10*eff_div cycles.
- busy = (state != IDLE). full = (count == FIFO_DEPTH). empty = (count == 0).
- FIFO pointers wrap modulo FIFO_DEPTH. count is $clog2(FIFO_DEPTH)+1 bits.
- Reset (asynchronous, including mid-frame):
  - state=IDLE, tx=1, FIFO flushed, count=0, overflow=0, DIV=DIV_RESET, baud counter=0, shift=0.
  - irq_empty=1 and read_data=0 (given no read).
  - A partial frame is abandoned with no stop bit.

Decomposition:
- Package mmio_uart_pkg: register offsets (OFF_TXDATA, OFF_STATUS, OFF_DIV), STATUS bit indices, FSM state enum (2-bit), default BASE_ADDR.
- One sub-module, uart_fifo: synchronous FIFO, parameter DEPTH/WIDTH=8.
  - Ports: push, pop, din, dout, full, empty, count.
  - Push-when-full-with-pop allowed; dout is the head, valid when not empty.

Test Plan:
- Reset then idle: hold reset 3 cycles, release -> tx=1, STATUS read = 32'h4, DIV read = 16, irq_empty=1.
- Single frame, DIV=4: write 0xA5 to TXDATA -> tx=0 starting 1 cycle after the write, then bits 1,0,1,0,0,1,0,1, then stop 1, each held 4 cycles. Frame is 40 cycles, then busy=0 and irq_empty=1.
- Back-to-back frames, DIV=2: push 0x01, 0x02, 0x03 on consecutive cycles -> three contiguous 20-cycle frames with no idle gap; STATUS.empty=1 after the first pop of 0x03.
- Overflow: DIV=100, push 6 bytes quickly:
  - first byte is popped immediately, next 4 fill the FIFO, the 6th is dropped;
  - STATUS = 32'hB (overflow, full, busy);
  - writing 0x8 to STATUS clears bit3, giving 32'h3.
- DIV edge cases:
  - DIV=0 -> 1-cycle bits, 10-cycle frame.
  - Writing DIV=8 mid DATA bit with old DIV=4 -> current bit still 4 cycles, next bits 8 cycles.
- Reset mid-frame: assert reset during DATA bit 3 with 2 bytes queued -> tx=1 immediately (asynchronous), STATUS=32'h4 after release, no further frames emitted.
